// File: rtl/unidad_control_multiciclo.sv
// Multicycle ARM-subset control unit.
// Moore FSM sequencing FETCH/DECODE/EXECUTE/writeback for data-processing,
// memory and branch instructions, with a 4-bit NZCV flags register that
// gates conditional execution of every architectural write.
module unidad_control_multiciclo (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXECUTER,
        EXECUTEI,
        ALUWB,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        BRANCH
    } state_t;

    // Instruction classes carried on Op
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Data-processing command encodings
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // ALU operation encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t     state;
    state_t     state_next;
    logic [3:0] flags;

    // Instruction field aliases
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       u_bit;
    logic       l_bit;
    logic       is_cmp;
    logic       cv_ops;
    logic       rd_is_pc;
    logic [1:0] dp_alu_ctrl;

    // Flag aliases
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_ex;
    logic       flags_we;

    assign i_bit    = Funct[5];
    assign cmd      = Funct[4:1];
    assign s_bit    = Funct[0];
    assign u_bit    = Funct[3];
    assign l_bit    = Funct[0];
    assign is_cmp   = (cmd == CMD_CMP);
    assign cv_ops   = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    assign rd_is_pc = (Rd == 4'd15);

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    // Data-processing command to ALU operation; unknown commands fall back to ADD
    always_comb begin
        dp_alu_ctrl = ALU_ADD;
        case (cmd)
            CMD_ADD: dp_alu_ctrl = ALU_ADD;
            CMD_SUB: dp_alu_ctrl = ALU_SUB;
            CMD_AND: dp_alu_ctrl = ALU_AND;
            CMD_ORR: dp_alu_ctrl = ALU_ORR;
            CMD_CMP: dp_alu_ctrl = ALU_SUB;
            default: dp_alu_ctrl = ALU_ADD;
        endcase
    end

    // Condition check against the registered flags
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Flags load only while executing a flag-setting (or CMP) instruction that passes its condition
    assign flags_we = ((state == EXECUTER) || (state == EXECUTEI)) && cond_ex && (s_bit || is_cmp);

    // Flags register: NZ from any flag-setting op, CV only from arithmetic ops
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= '0;
        end else if (flags_we) begin
            flags[3:2] <= ALUFlags[3:2];
            if (cv_ops) begin
                flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (Op)
                    OP_DP:   state_next = i_bit ? EXECUTEI : EXECUTER;
                    OP_MEM:  state_next = MEMADR;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            MEMADR:   state_next = l_bit ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = FETCH;
            BRANCH:   state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // Moore outputs per state; architectural write strobes are suppressed while reset is high
    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = {(Op == OP_MEM) & ~Funct[0], (Op == OP_BR)};
            end
            EXECUTER: begin
                ALUControl = dp_alu_ctrl;
            end
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu_ctrl;
            end
            ALUWB: begin
                RegWrite = cond_ex & ~is_cmp & ~rd_is_pc;
                PCWrite  = cond_ex & ~is_cmp & rd_is_pc;
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex & ~rd_is_pc;
                PCWrite   = cond_ex & rd_is_pc;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b01;
                ResultSrc = 2'b10;
                RegSrc    = 2'b01;
                PCWrite   = cond_ex;
            end
            default: begin
            end
        endcase
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed cycle-by-cycle vectors for the multicycle control unit.
// Each record holds the inputs presented during one clock cycle and the
// packed set of Moore outputs expected in that cycle.
module tb_unidad_control_multiciclo;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;

    unidad_control_multiciclo dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [3:0]  alf;
        logic [15:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   idx   = 0;

    // Instruction fields currently being built into the table
    logic [3:0] cur_cond;
    logic [1:0] cur_op;
    logic [5:0] cur_funct;
    logic [3:0] cur_rd;
    logic [3:0] cur_alf;

    // Packed output order: PCWrite MemWrite IRWrite RegWrite AdrSrc ALUSrcA ALUSrcB ALUControl ResultSrc ImmSrc RegSrc
    function automatic logic [15:0] o(input logic pcw, input logic mw, input logic irw, input logic rw,
                                      input logic adr, input logic sa, input logic [1:0] sb,
                                      input logic [1:0] ac, input logic [1:0] rs, input logic [1:0] im,
                                      input logic [1:0] rg);
        return {pcw, mw, irw, rw, adr, sa, sb, ac, rs, im, rg};
    endfunction

    function automatic void set_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                                      input logic [3:0] rd, input logic [3:0] alf);
        cur_cond  = c;
        cur_op    = op;
        cur_funct = f;
        cur_rd    = rd;
        cur_alf   = alf;
    endfunction

    function automatic vec_t mk(input logic rst, input logic [15:0] exp);
        vec_t v;
        v.rst   = rst;
        v.cond  = cur_cond;
        v.op    = cur_op;
        v.funct = cur_funct;
        v.rd    = cur_rd;
        v.alf   = cur_alf;
        v.exp   = exp;
        return v;
    endfunction

    function automatic void add(input logic rst, input logic [15:0] exp);
        vq.push_back(mk(rst, exp));
    endfunction

    task automatic apply(input vec_t v, input bit chk);
        logic [15:0] got;
        @(negedge clk);
        reset    = v.rst;
        Cond     = v.cond;
        Op       = v.op;
        Funct    = v.funct;
        Rd       = v.rd;
        ALUFlags = v.alf;
        #1;
        got = {PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc};
        if (chk) begin
            n_vec++;
            if (got !== v.exp) begin
                n_bad++;
                $display("FAIL vec %0d: outputs %b, expected %b", idx, got, v.exp);
            end
        end
        idx++;
    endtask

    task automatic step(input logic rst, input logic [15:0] exp);
        apply(mk(rst, exp), 1'b1);
    endtask

    logic [15:0] F_O, F_RST, D_00, D_01, D_10, ZERO;

    initial begin
        reset    = 1'b1;
        Cond     = '0;
        Op       = '0;
        Funct    = '0;
        Rd       = '0;
        ALUFlags = '0;

        F_O   = o(1, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
        F_RST = o(0, 0, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
        D_00  = o(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
        D_01  = o(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01);
        D_10  = o(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10);
        ZERO  = '0;

        // Reset: first cycle from unknown state unchecked, second in FETCH with PCWrite masked
        set_instr(4'b1110, 2'b00, 6'b000000, 4'd0, 4'b0000);
        apply(mk(1'b1, ZERO), 1'b0);
        step(1'b1, F_RST);

        // ADD R1 (register): RegWrite only in ALUWB
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000);
        add(0, F_O); add(0, D_00); add(0, ZERO);
        add(0, o(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // ADD R15: write goes to PC instead
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
        add(0, F_O); add(0, D_00); add(0, ZERO);
        add(0, o(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // ANDS R5 with ALUFlags=1011: NZ load 10, CV hold 00 -> flags 1000
        set_instr(4'b1110, 2'b00, 6'b000001, 4'd5, 4'b1011);
        add(0, F_O); add(0, D_00);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00));
        add(0, o(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // BCS: C=0, not taken (ALUFlags ignored)
        set_instr(4'b0010, 2'b10, 6'b000000, 4'd0, 4'b1111);
        add(0, F_O); add(0, D_01);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01));
        // BMI: N=1, taken
        set_instr(4'b0100, 2'b10, 6'b000000, 4'd0, 4'b0000);
        add(0, F_O); add(0, D_01);
        add(0, o(1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01));
        // CMP with S=1, ALUFlags=0100 -> flags 0100; no register write
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100);
        add(0, F_O); add(0, D_00);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
        add(0, ZERO);
        // ORR immediate, S=0: flags must hold
        set_instr(4'b1110, 2'b00, 6'b111000, 4'd2, 4'b0000);
        add(0, F_O); add(0, D_00);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00));
        add(0, o(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // BEQ: Z=1, taken
        set_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        add(0, F_O); add(0, D_01);
        add(0, o(1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01));
        // BNE: not taken
        set_instr(4'b0001, 2'b10, 6'b000000, 4'd0, 4'b0000);
        add(0, F_O); add(0, D_01);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01));
        // LDR R15, U=0 L=1
        set_instr(4'b1110, 2'b01, 6'b000001, 4'd15, 4'b0000);
        add(0, F_O); add(0, D_00);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00));
        add(0, o(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        add(0, o(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
        // LDR R4, U=1 L=1
        set_instr(4'b1110, 2'b01, 6'b001001, 4'd4, 4'b0000);
        add(0, F_O); add(0, D_00);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00));
        add(0, o(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        add(0, o(0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
        // STRNE with Z=1: MemWrite suppressed
        set_instr(4'b0001, 2'b01, 6'b001000, 4'd3, 4'b0000);
        add(0, F_O); add(0, D_10);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00));
        add(0, o(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // STR always
        set_instr(4'b1110, 2'b01, 6'b001000, 4'd3, 4'b0000);
        add(0, F_O); add(0, D_10);
        add(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00));
        add(0, o(0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // Unsupported Op=11: two cycles, no writes
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
        add(0, F_O); add(0, D_00);

        foreach (vq[i]) apply(vq[i], 1'b1);

        // Reset in MEMREAD aborts the load; next cycle is FETCH
        set_instr(4'b1110, 2'b01, 6'b001001, 4'd4, 4'b0000);
        step(0, F_O); step(0, D_00);
        step(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00));
        step(1, o(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // Flags were 0100 before reset; cleared flags make BEQ not taken
        set_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0000);
        step(0, F_O); step(0, D_01);
        step(0, o(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01));

        // Reset in ALUWB masks RegWrite, then restart at FETCH
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000);
        step(0, F_O); step(0, D_00); step(0, ZERO);
        step(1, ZERO);
        step(0, F_O);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
